// File: rtl/bcd_score_accumulator_pkg.sv
// Shared types and constants for the BCD score accumulator.
// FSM state encoding, BCD digit width and the largest legal digit value.
package bcd_score_accumulator_pkg;

  localparam int DW = 4;
  localparam logic [DW-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_CMP
  } state_t;

endpackage

// File: rtl/bcd_score_accumulator_digit_add.sv
// One-digit BCD adder; clamps b to 9 and applies the +6 decimal correction.
// Ports: a, b digits, cin carry in; s sum digit, cout carry out.
module bcd_digit_add
  import bcd_score_accumulator_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW-1:0] bc;
  logic [DW:0]   raw;

  always_comb begin
    bc   = (b > BCD_MAX) ? BCD_MAX : b;
    raw  = {1'b0, a} + {1'b0, bc}
         + {{DW{1'b0}}, cin};
    cout = raw > {1'b0, BCD_MAX};
    // raw + 6 mod 16 is raw - 10 for raw in 10..19
    s    = cout ? raw[DW-1:0] + DW'(6)
                : raw[DW-1:0];
  end

endmodule

// File: rtl/bcd_score_accumulator.sv
// Serial BCD score accumulator with high score, wrap/saturate overflow.
// Ports: CLK, RST (sync low), clr, add_valid/add_ready/add_val, score, hiscore, overflow, new_hi.
module bcd_score_accumulator
  import bcd_score_accumulator_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ADD_DIGITS = 2,
  parameter bit WRAP       = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     add_valid,
  output logic                     add_ready,
  input  logic [ADD_DIGITS*DW-1:0] add_val,
  output logic [DIGITS*DW-1:0]     score,
  output logic [DIGITS*DW-1:0]     hiscore,
  output logic                     overflow,
  output logic                     new_hi
);

  localparam int W  = DIGITS * DW;
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t state, state_n;

  logic [W-1:0]  work;
  logic [W-1:0]  inc;
  logic [IW-1:0] idx;
  logic          carry;
  logic          ovf_pend;

  logic [DW-1:0] a_dig;
  logic [DW-1:0] b_dig;
  logic [DW-1:0] s_dig;
  logic          c_out;

  logic [W-1:0]  all9;
  logic [W-1:0]  result;

  assign add_ready = (state == S_IDLE);
  assign all9      = {DIGITS{BCD_MAX}};
  assign result    = (ovf_pend && !WRAP)
                   ? all9 : work;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        a_dig = work[k*DW +: DW];
        b_dig = inc[k*DW +: DW];
      end
    end
  end

  bcd_digit_add u_dig (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (c_out)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (add_valid) state_n = S_ADD;
        S_ADD:
          if (idx == LAST) state_n = S_CMP;
        S_CMP:
          state_n = S_IDLE;
        default:
          state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      score    <= '0;
      hiscore  <= '0;
      overflow <= 1'b0;
      new_hi   <= 1'b0;
      work     <= '0;
      inc      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      new_hi <= 1'b0;
      if (clr) begin
        score    <= '0;
        overflow <= 1'b0;
        work     <= '0;
        inc      <= '0;
        idx      <= '0;
        carry    <= 1'b0;
        ovf_pend <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (add_valid) begin
              inc      <= W'(add_val);
              work     <= score;
              idx      <= '0;
              carry    <= 1'b0;
              ovf_pend <= 1'b0;
            end
          end
          S_ADD: begin
            for (int k = 0; k < DIGITS; k++) begin
              if (idx == IW'(k))
                work[k*DW +: DW] <= s_dig;
            end
            carry <= c_out;
            idx   <= idx + 1'b1;
            if (idx == LAST) begin
              ovf_pend <= c_out;
              idx      <= '0;
            end
          end
          S_CMP: begin
            score <= result;
            if (ovf_pend) overflow <= 1'b1;
            // valid BCD orders the same as its binary image
            if (result > hiscore) begin
              hiscore <= result;
              new_hi  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Randomized self-checking bench for bcd_score_accumulator.
// Runs a wrap and a saturate instance in lockstep against an integer model.
module tb_bcd_score_accumulator;

  localparam int D    = 4;
  localparam int AD   = 2;
  localparam int MAXV = 10000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic        add_valid;
  logic [7:0]  add_val;

  logic        rdy_w, rdy_s;
  logic [15:0] sc_w, sc_s, hi_w, hi_s;
  logic        ov_w, ov_s, nh_w, nh_s;

  int n_checks = 0;
  int n_errors = 0;

  int m_sw, m_ss, m_hw, m_hs;
  bit m_ow, m_os;

  always #5 CLK = ~CLK;

  bcd_score_accumulator #(
    .DIGITS(D), .ADD_DIGITS(AD), .WRAP(1'b1)
  ) u_wrap (
    .CLK(CLK), .RST(RST), .clr(clr),
    .add_valid(add_valid), .add_ready(rdy_w),
    .add_val(add_val), .score(sc_w),
    .hiscore(hi_w), .overflow(ov_w),
    .new_hi(nh_w)
  );

  bcd_score_accumulator #(
    .DIGITS(D), .ADD_DIGITS(AD), .WRAP(1'b0)
  ) u_sat (
    .CLK(CLK), .RST(RST), .clr(clr),
    .add_valid(add_valid), .add_ready(rdy_s),
    .add_val(add_val), .score(sc_s),
    .hiscore(hi_s), .overflow(ov_s),
    .new_hi(nh_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < D; k++)
      r[k*4 +: 4] = 4'((v / (10 ** k)) % 10);
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".score_w"}, 32'(sc_w), 32'(to_bcd(m_sw)));
    chk({tag, ".score_s"}, 32'(sc_s), 32'(to_bcd(m_ss)));
    chk({tag, ".hi_w"}, 32'(hi_w), 32'(to_bcd(m_hw)));
    chk({tag, ".hi_s"}, 32'(hi_s), 32'(to_bcd(m_hs)));
    chk({tag, ".ovf_w"}, 32'(ov_w), 32'(m_ow));
    chk({tag, ".ovf_s"}, 32'(ov_s), 32'(m_os));
    chk({tag, ".rdy_w"}, 32'(rdy_w), 32'd1);
    chk({tag, ".rdy_s"}, 32'(rdy_s), 32'd1);
  endtask

  task automatic model_reset();
    m_sw = 0; m_ss = 0; m_hw = 0; m_hs = 0;
    m_ow = 0; m_os = 0;
  endtask

  task automatic do_add(input logic [7:0] v);
    int inc, d, busy, sw, ss;
    bit pw, ps;
    inc = 0;
    for (int k = 0; k < AD; k++) begin
      d = int'(v[k*4 +: 4]);
      if (d > 9) d = 9;
      inc += d * (10 ** k);
    end
    add_valid = 1'b1;
    add_val   = v;
    @(posedge CLK);
    busy = 0;
    forever begin
      @(negedge CLK);
      add_valid = 1'b0;
      if (rdy_w) break;
      busy++;
      if (busy > 20) break;
      chk("hold.score_w", 32'(sc_w), 32'(to_bcd(m_sw)));
      chk("hold.score_s", 32'(sc_s), 32'(to_bcd(m_ss)));
      chk("hold.newhi", 32'({nh_w, nh_s}), 32'd0);
      // requests while busy must be dropped
      add_valid = 1'($urandom_range(0, 1));
      add_val   = 8'($urandom);
    end
    add_valid = 1'b0;
    chk("busy_cycles", 32'(busy), 32'(D + 1));

    sw = m_sw + inc;
    if (sw >= MAXV) begin m_ow = 1; sw -= MAXV; end
    ss = m_ss + inc;
    if (ss >= MAXV) begin m_os = 1; ss = MAXV - 1; end
    m_sw = sw; m_ss = ss;
    pw = (sw > m_hw); if (pw) m_hw = sw;
    ps = (ss > m_hs); if (ps) m_hs = ss;
    check_all("add");
    chk("newhi_w", 32'(nh_w), 32'(pw));
    chk("newhi_s", 32'(nh_s), 32'(ps));
  endtask

  task automatic do_clr();
    clr       = 1'b1;
    add_valid = 1'b1;
    add_val   = 8'($urandom);
    @(posedge CLK);
    @(negedge CLK);
    clr       = 1'b0;
    add_valid = 1'b0;
    m_sw = 0; m_ss = 0; m_ow = 0; m_os = 0;
    check_all("clr");
    chk("clr.newhi", 32'({nh_w, nh_s}), 32'd0);
  endtask

  task automatic abort_add(input bit use_rst);
    add_valid = 1'b1;
    add_val   = 8'($urandom);
    @(posedge CLK);
    @(negedge CLK);
    add_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    if (use_rst) RST = 1'b0;
    else         clr = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    clr = 1'b0;
    if (use_rst) model_reset();
    else begin
      m_sw = 0; m_ss = 0; m_ow = 0; m_os = 0;
    end
    check_all(use_rst ? "midrst" : "midclr");
    chk("abort.newhi", 32'({nh_w, nh_s}), 32'd0);
  endtask

  initial begin
    RST       = 1'b0;
    clr       = 1'b0;
    add_valid = 1'b1;
    add_val   = 8'h10;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all("reset");
    chk("reset.newhi", 32'({nh_w, nh_s}), 32'd0);
    add_valid = 1'b0;
    RST       = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_all("post_reset");

    repeat (3) do_add(8'h10);
    chk("hi30", 32'(hi_w), 32'h0030);

    do_clr();
    do_add(8'h05);
    abort_add(1'b0);

    do_add(8'h1C);
    do_add(8'hCC);

    do_clr();
    repeat (10) do_add(8'h99);
    do_add(8'h05);
    do_add(8'h07);
    chk("carry1002", 32'(sc_w), 32'h1002);

    do_clr();
    repeat (100) do_add(8'h99);
    do_add(8'h90);
    do_add(8'h25);
    chk("wrap0015", 32'(sc_w), 32'h0015);
    chk("sat9999", 32'(sc_s), 32'h9999);
    do_add(8'h01);
    chk("sat_hold", 32'(sc_s), 32'h9999);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_clr();
      else do_add(8'($urandom));
    end

    abort_add(1'b1);
    do_add(8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
